// File: rtl/operand_select_stage_pkg.sv
// Shared constants for the operand-select / ID-EX stage: default widths
// and the hard-wired zero register index.
package operand_select_stage_pkg;

   localparam int XLEN_DEFAULT       = 32;
   localparam int NUM_FWD_DEFAULT    = 3;
   localparam int REG_ADDR_W_DEFAULT = 5;
   localparam int CNT_W_DEFAULT      = 16;

   localparam int X0 = 0;

endpackage

// File: rtl/operand_select_stage_bypass.sv
// One operand's bypass resolution: the lowest-index matching source wins,
// x0 always reads as zero, and only the winner's pending flag raises a hazard.
module operand_bypass_mux
   import operand_select_stage_pkg::*;
#(
   parameter int XLEN       = XLEN_DEFAULT,
   parameter int NUM_FWD    = NUM_FWD_DEFAULT,
   parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
   input  logic [REG_ADDR_W-1:0]         rs_addr,
   input  logic [XLEN-1:0]               rs_data,
   input  logic [NUM_FWD-1:0]            fwd_en,
   input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr,
   input  logic [NUM_FWD*XLEN-1:0]       fwd_data,
   input  logic [NUM_FWD-1:0]            fwd_pending,
   output logic [XLEN-1:0]               value,
   output logic                          hazard
);

   always_comb begin
      value  = rs_data;
      hazard = 1'b0;
      // Walk from oldest to youngest so the youngest match overwrites last.
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (fwd_en[i] && (fwd_addr[i*REG_ADDR_W +: REG_ADDR_W] == rs_addr)) begin
            value  = fwd_data[i*XLEN +: XLEN];
            hazard = fwd_pending[i];
         end
      end
      if (rs_addr == REG_ADDR_W'(X0)) begin
         value  = '0;
         hazard = 1'b0;
      end
   end

endmodule

// File: rtl/operand_select_stage.sv
// Operand-select and ID/EX register: resolves both ALU operands through the
// bypass network, stalls on load-use hazards and registers the result.
module operand_select_stage
   import operand_select_stage_pkg::*;
#(
   parameter int XLEN       = XLEN_DEFAULT,
   parameter int NUM_FWD    = NUM_FWD_DEFAULT,
   parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
   parameter int CNT_W      = CNT_W_DEFAULT
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          io_in_valid,
   output logic                          io_in_ready,
   input  logic [REG_ADDR_W-1:0]         io_rs1_addr,
   input  logic [REG_ADDR_W-1:0]         io_rs2_addr,
   input  logic [XLEN-1:0]               io_rs1_data,
   input  logic [XLEN-1:0]               io_rs2_data,
   input  logic [XLEN-1:0]               io_imm,
   input  logic                          io_immsrc,
   input  logic                          io_islui,
   input  logic [NUM_FWD-1:0]            io_fwd_en,
   input  logic [NUM_FWD*REG_ADDR_W-1:0] io_fwd_addr,
   input  logic [NUM_FWD*XLEN-1:0]       io_fwd_data,
   input  logic [NUM_FWD-1:0]            io_fwd_pending,
   input  logic                          io_flush,
   output logic                          io_out_valid,
   input  logic                          io_out_ready,
   output logic [XLEN-1:0]               io_alu_in1,
   output logic [XLEN-1:0]               io_alu_in2,
   output logic [XLEN-1:0]               io_store_data,
   output logic [CNT_W-1:0]              io_stall_cnt
);

   logic [XLEN-1:0] fwd1;
   logic [XLEN-1:0] fwd2;
   logic            haz1;
   logic            haz2;
   logic            hazard;
   logic            accept;

   operand_bypass_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_ADDR_W(REG_ADDR_W)) u_rs1_mux (
      .rs_addr     (io_rs1_addr),
      .rs_data     (io_rs1_data),
      .fwd_en      (io_fwd_en),
      .fwd_addr    (io_fwd_addr),
      .fwd_data    (io_fwd_data),
      .fwd_pending (io_fwd_pending),
      .value       (fwd1),
      .hazard      (haz1)
   );

   operand_bypass_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_ADDR_W(REG_ADDR_W)) u_rs2_mux (
      .rs_addr     (io_rs2_addr),
      .rs_data     (io_rs2_data),
      .fwd_en      (io_fwd_en),
      .fwd_addr    (io_fwd_addr),
      .fwd_data    (io_fwd_data),
      .fwd_pending (io_fwd_pending),
      .value       (fwd2),
      .hazard      (haz2)
   );

   // Handshake: a transfer happens on a rising edge where valid && ready.
   // Ready never looks at valid; valid, once raised, holds its payload
   // until the transfer (or a flush) happens.
   assign hazard      = haz1 || haz2;
   assign io_in_ready = !io_flush && !hazard && (!io_out_valid || io_out_ready);
   assign accept      = io_in_valid && io_in_ready;

   always_ff @(posedge clock) begin
      if (!reset) begin
         io_out_valid  <= 1'b0;
         io_alu_in1    <= '0;
         io_alu_in2    <= '0;
         io_store_data <= '0;
         io_stall_cnt  <= '0;
      end else begin
         if (io_flush) begin
            io_out_valid <= 1'b0;
         end else if (accept) begin
            io_out_valid  <= 1'b1;
            io_alu_in1    <= io_islui ? '0 : fwd1;
            io_alu_in2    <= io_immsrc ? io_imm : fwd2;
            io_store_data <= fwd2;
         end else if (io_out_ready) begin
            io_out_valid <= 1'b0;
         end
         if (io_in_valid && hazard && !io_flush && (io_stall_cnt != '1)) begin
            io_stall_cnt <= io_stall_cnt + 1'b1;
         end
      end
   end

endmodule
